btb_nway: RTL

BTB_NWAY -- requirements
Module: btb_nway

---
 rtl/btb_nway.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/btb_nway.sv
// Purpose: N-way set-associative branch target buffer with 2-bit counters.
// Latency: lookup result registered, valid one cycle after lookup_valid.
// Backpressure: none; accepts a lookup and an update every cycle.
// Ports: clk/rst_n; lookup_valid/lookup_pc -> pred_valid/hit/taken/target/way
//        (one cycle later); upd_valid/upd_pc/upd_taken/upd_target train the
//        table; flush clears all valid bits.
module btb_nway #(
    parameter int WAYS = 2,
    parameter int SETS = 16,
    parameter int PC_W = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   lookup_valid,
    input  logic [PC_W-1:0]                        lookup_pc,
    output logic                                   pred_valid,
    output logic                                   pred_hit,
    output logic                                   pred_taken,
    output logic [PC_W-1:0]                        pred_target,
    output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] pred_way,
    input  logic                                   upd_valid,
    input  logic [PC_W-1:0]                        upd_pc,
    input  logic                                   upd_taken,
    input  logic [PC_W-1:0]                        upd_target,
    input  logic                                   flush
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = PC_W - 2 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Table state
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  valid_d [SETS];
    logic [1:0]       ctr_q   [SETS][WAYS];
    logic [1:0]       ctr_d   [SETS][WAYS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [TAG_W-1:0] tag_d   [SETS][WAYS];
    logic [PC_W-1:0]  tgt_q   [SETS][WAYS];
    logic [PC_W-1:0]  tgt_d   [SETS][WAYS];
    logic [WAY_W-1:0] ptr_q   [SETS];
    logic [WAY_W-1:0] ptr_d   [SETS];

    // Prediction registers
    logic             pred_valid_q, pred_valid_d;
    logic             pred_hit_q,   pred_hit_d;
    logic             pred_taken_q, pred_taken_d;
    logic [PC_W-1:0]  pred_target_q, pred_target_d;
    logic [WAY_W-1:0] pred_way_q,   pred_way_d;

    // PC bits [1:0] never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // ---------------- Lookup path (reads pre-update state) ----------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [WAY_W-1:0] lk_way;

    always_comb begin
        lk_idx = lookup_pc[IDX_W+1:2];
        lk_tag = lookup_pc[PC_W-1:IDX_W+2];
        lk_hit = 1'b0;
        lk_way = '0;
        // Scan downwards so the lowest matching way is the last one written.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
        end
        pred_valid_d  = lookup_valid;
        pred_hit_d    = lookup_valid && lk_hit;
        pred_taken_d  = 1'b0;
        pred_target_d = '0;
        pred_way_d    = '0;
        if (lookup_valid && lk_hit) begin
            pred_taken_d  = ctr_q[lk_idx][lk_way][1];
            pred_target_d = tgt_q[lk_idx][lk_way];
            pred_way_d    = lk_way;
        end
    end

    // ---------------- Update path ----------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [WAY_W-1:0] up_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] alloc_way;

    always_comb begin
        up_idx    = upd_pc[IDX_W+1:2];
        up_tag    = upd_pc[PC_W-1:IDX_W+2];
        up_hit    = 1'b0;
        up_way    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
                up_hit = 1'b1;
                up_way = WAY_W'(w);
            end
            if (!valid_q[up_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        alloc_way = inv_found ? inv_way : ptr_q[up_idx];

        valid_d = valid_q;
        ctr_d   = ctr_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ptr_d   = ptr_q;

        if (flush) begin
            // Only valid bits drop; training history and pointers survive.
            for (int s = 0; s < SETS; s++) begin
                valid_d[s] = '0;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (ctr_q[up_idx][up_way] != 2'b11) begin
                        ctr_d[up_idx][up_way] = ctr_q[up_idx][up_way] + 2'b01;
                    end
                    tgt_d[up_idx][up_way] = upd_target;
                end else if (ctr_q[up_idx][up_way] != 2'b00) begin
                    ctr_d[up_idx][up_way] = ctr_q[up_idx][up_way] - 2'b01;
                end
            end else if (upd_taken) begin
                valid_d[up_idx][alloc_way] = 1'b1;
                tag_d[up_idx][alloc_way]   = up_tag;
                tgt_d[up_idx][alloc_way]   = upd_target;
                ctr_d[up_idx][alloc_way]   = 2'b10;
                // Round-robin advances only when a live entry is evicted;
                // WAYS is a power of two so the add wraps naturally.
                if ((WAYS > 1) && !inv_found) begin
                    ptr_d[up_idx] = ptr_q[up_idx] + 1'b1;
                end
            end
        end
    end

    // ---------------- State ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    ctr_q[s][w] <= 2'b00;
                end
            end
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_way_q    <= '0;
        end else begin
            valid_q       <= valid_d;
            ptr_q         <= ptr_d;
            ctr_q         <= ctr_d;
            pred_valid_q  <= pred_valid_d;
            pred_hit_q    <= pred_hit_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            pred_way_q    <= pred_way_d;
        end
    end

    // Tags and targets are qualified by valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

    assign pred_valid  = pred_valid_q;
    assign pred_hit    = pred_hit_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;
    assign pred_way    = (WAYS > 1) ? pred_way_q : '0;

endmodule
